// File: rtl/pixel_sink.sv
// Frame-buffer sink: drawing FSMs plot pixels into a 3-bit-per-pixel buffer,
// and a scan FSM streams one full frame out in raster order on request.
module pixel_sink #(
  parameter int X_SCREEN_PIXELS = 160,
  parameter int Y_SCREEN_PIXELS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  input  logic       scanStart,
  output logic [7:0] pixX,
  output logic [6:0] pixY,
  output logic [2:0] pixColour,
  output logic       pixValid,
  output logic       frameDone,
  output logic       busy,
  output logic [7:0] dropCount
);

  localparam int DEPTH = X_SCREEN_PIXELS * Y_SCREEN_PIXELS;
  localparam int AW    = 15;
  localparam logic [7:0] X_LIM  = 8'(X_SCREEN_PIXELS);
  localparam logic [6:0] Y_LIM  = 7'(Y_SCREEN_PIXELS);
  localparam logic [7:0] X_LAST = 8'(X_SCREEN_PIXELS - 1);
  localparam logic [6:0] Y_LAST = 7'(Y_SCREEN_PIXELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH} state_t;

  state_t      state_q, state_d;
  logic [7:0]  scan_x_q, scan_x_d;
  logic [6:0]  scan_y_q, scan_y_d;
  logic        plot_q, plot_d;
  logic [7:0]  wx_q, wx_d;
  logic [6:0]  wy_q, wy_d;
  logic [2:0]  wcol_q, wcol_d;
  logic [7:0]  drop_q, drop_d;
  logic        pix_valid_q, pix_valid_d;
  logic [7:0]  pix_x_q, pix_x_d;
  logic [6:0]  pix_y_q, pix_y_d;
  logic [2:0]  rd_data_q;
  logic        rd_en, wr_en, in_range;
  logic [AW-1:0] wr_addr, rd_addr;

  logic [2:0] fb_mem [DEPTH];

  // Write path: the plot is captured first, then range-checked and committed one edge later.
  always_comb begin
    plot_d   = plot;
    wx_d     = x;
    wy_d     = y;
    wcol_d   = colour;
    in_range = (wx_q < X_LIM) && (wy_q < Y_LIM);
    wr_en    = plot_q && in_range && !reset;
    wr_addr  = AW'(wy_q) * AW'(X_SCREEN_PIXELS) + AW'(wx_q);
    drop_d   = drop_q;
    if (plot_q && !in_range && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    scan_x_d = scan_x_q;
    scan_y_d = scan_y_q;
    rd_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (scanStart) begin
          state_d  = S_SCAN;
          scan_x_d = 8'd0;
          scan_y_d = 7'd0;
        end
      end
      S_SCAN: begin
        rd_en = 1'b1;
        if (scan_x_q == X_LAST) begin
          scan_x_d = 8'd0;
          if (scan_y_q == Y_LAST) begin
            scan_y_d = 7'd0;
            state_d  = S_FLUSH;
          end else begin
            scan_y_d = scan_y_q + 7'd1;
          end
        end else begin
          scan_x_d = scan_x_q + 8'd1;
        end
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    rd_addr     = AW'(scan_y_q) * AW'(X_SCREEN_PIXELS) + AW'(scan_x_q);
    pix_valid_d = rd_en;
    pix_x_d     = rd_en ? scan_x_q : 8'd0;
    pix_y_d     = rd_en ? scan_y_q : 7'd0;
  end

  // Read-first: a same-address write in this cycle is seen only by later reads.
  always_ff @(posedge clk) begin
    if (wr_en) fb_mem[wr_addr] <= wcol_q;
    if (rd_en) rd_data_q <= fb_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      scan_x_q    <= 8'd0;
      scan_y_q    <= 7'd0;
      plot_q      <= 1'b0;
      wx_q        <= 8'd0;
      wy_q        <= 7'd0;
      wcol_q      <= 3'd0;
      drop_q      <= 8'd0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= 8'd0;
      pix_y_q     <= 7'd0;
    end else begin
      state_q     <= state_d;
      scan_x_q    <= scan_x_d;
      scan_y_q    <= scan_y_d;
      plot_q      <= plot_d;
      wx_q        <= wx_d;
      wy_q        <= wy_d;
      wcol_q      <= wcol_d;
      drop_q      <= drop_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
    end
  end

  assign pixValid  = pix_valid_q;
  assign pixX      = pix_x_q;
  assign pixY      = pix_y_q;
  assign pixColour = pix_valid_q ? rd_data_q : 3'd0;
  assign frameDone = pix_valid_q && (pix_x_q == X_LAST) && (pix_y_q == Y_LAST);
  assign busy      = (state_q != S_IDLE);
  assign dropCount = drop_q;

endmodule
